reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised general-purpose register file with integrated scoreboard; successor to the single-write/dual-read 64-bit register file.
- Sits between decode/issue and writeback: NRP read ports with same-cycle write bypass, NWP write ports with fixed priority, and per-register busy bits for RAW hazard detection.
- Issue logic uses the busy status to stall; a flush clears all pending producers.

Parameters:
XLEN, 64, data width of each register
NREG, 32, number of architectural registers; register 0 is hardwired zero
AW, 5, register address width; must equal clog2(NREG)
NRP, 2, number of read ports
NWP, 2, number of write ports; higher index has higher priority

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
i_wen  input  NWP  per-write-port enable
i_waddr  input  NWP*AW  write addresses, port k at bits [k*AW +: AW]
i_wdata  input  NWP*XLEN  write data, port k at bits [k*XLEN +: XLEN]
i_ren  input  NRP  per-read-port enable
i_raddr  input  NRP*AW  read addresses, port j at bits [j*AW +: AW]
o_rdata  output  NRP*XLEN  read data, combinational
o_rbusy  output  NRP  read operand still pending, combinational
i_issue  input  1  instruction with destination issued this cycle
i_issue_addr  input  AW  destination register of issuing instruction
i_flush  input  1  clear all busy bits
o_busy_vec  output  NREG  registered scoreboard state, bit 0 always 0

Behaviour:
- Reset (rst_n low, async): all NREG registers <= 0; all busy bits <= 0. While in reset o_busy_vec = 0, o_rbusy = 0, o_rdata = 0.
- Write, posedge clk: for each register r != 0, if any port k has i_wen[k] and waddr[k]==r, the highest such k writes wdata[k]. Lower-index writes to the same r that cycle are dropped. Writes to r=0 are ignored.
- Read, per port j, combinational, priority order:
  1. raddr==0 -> 0.
  2. i_ren[j]==0 -> 0.
  3. Bypass: data from the highest-index write port with i_wen and waddr==raddr.
  4. Otherwise the array value.
  - Read-during-write returns new data with zero latency.
- Scoreboard, posedge clk, per register r != 0:
  - set_r = i_issue & issue_addr==r.
  - clr_r = any i_wen[k] with waddr[k]==r.
  - Next state:
    - i_flush: busy <= 0 for all r. Flush overrides set and clear; a same-cycle issue is not recorded.
    - else set_r: busy <= 1. Set wins over a same-cycle clear, since the new producer supersedes the completing one.
    - else clr_r: busy <= 0.
    - else hold.
  - i_issue with issue_addr==0: no effect.
  - bit 0 is constant 0.
- o_rbusy[j] = i_ren[j] & raddr!=0 & busy[raddr] & ~(bypass hit on port j).
  - A writeback completing this cycle hides the hazard.
  - A same-cycle issue does not affect o_rbusy until the next cycle.
- Writes are never blocked by busy state. A write to a non-busy register updates data and leaves busy at 0.
- No internal state machine beyond the array and busy vector. Read latency 0; write and scoreboard latency 1 cycle.
- Parameter legality: NRP>=1, NWP>=1, NREG<=2^AW. Checked by simulation-only assertion; no RTL error handling.

Test Plan:
- Reset then read: rst_n low mid-run after writing 0x5A to x3, release; read x3 on port 0 with ren=1 -> 0, o_busy_vec=0.
- Bypass and x0:
  - wen[0]=1, waddr=7, wdata=0x1234, raddr0=7 same cycle -> rdata0=0x1234.
  - Next cycle, ren=0 on port 1 with raddr=7 -> 0.
  - Write x0=0xFF, then read x0 -> 0.
- Write priority: wen=2'b11, waddr0=waddr1=9, wdata0=0xAAAA, wdata1=0xBBBB -> same-cycle rdata=0xBBBB; array x9=0xBBBB after the edge.
- Scoreboard set/clear:
  - Issue x5 -> next cycle busy_vec[5]=1; read x5 -> rbusy=1.
  - Write x5=0x77 same cycle as the read -> rbusy=0, rdata=0x77.
  - Next cycle busy_vec[5]=0.
- Simultaneous events:
  - Busy x6, issue x6 and write x6 in the same cycle -> busy_vec[6] stays 1.
  - Issue x8 with i_flush=1 -> busy_vec all 0 next cycle.
  - Issue x0 -> busy_vec[0]=0.
- Parameter sweep: XLEN=32, NREG=16, AW=4, NRP=3, NWP=1. Random writes/reads/issues checked against a reference model for data and busy state over 10k cycles.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: general-purpose register file with an integrated scoreboard.
//
// Sits between decode/issue and writeback. Register 0 reads as zero and
// ignores writes. Writes land on the clock edge; reads are combinational and
// see same-cycle writes through a bypass. One busy bit per register tracks
// in-flight producers so issue logic can stall on RAW hazards.
//
// Ports
//   clk, rst_n     clock; asynchronous active-low reset
//   i_wen          per-write-port enable (NWP)
//   i_waddr        write addresses, port k at [k*AW +: AW]
//   i_wdata        write data, port k at [k*XLEN +: XLEN]
//   i_ren          per-read-port enable (NRP)
//   i_raddr        read addresses, port j at [j*AW +: AW]
//   o_rdata        read data, port j at [j*XLEN +: XLEN], combinational
//   o_rbusy        operand of read port j still pending, combinational
//   i_issue        an instruction with a destination issues this cycle
//   i_issue_addr   destination register of the issuing instruction
//   i_flush        clear every busy bit
//   o_busy_vec     registered scoreboard state, bit 0 always 0
//
// Handshake: there is no valid/ready pair. Every enable (i_wen, i_ren,
// i_issue, i_flush) is a single-cycle qualifier sampled at the rising edge;
// the block never back-pressures and writes are never blocked by busy state.
module reg_file_sb #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRP  = 2,
    parameter int NWP  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NWP-1:0]      i_wen,
    input  logic [NWP*AW-1:0]   i_waddr,
    input  logic [NWP*XLEN-1:0] i_wdata,
    input  logic [NRP-1:0]      i_ren,
    input  logic [NRP*AW-1:0]   i_raddr,
    output logic [NRP*XLEN-1:0] o_rdata,
    output logic [NRP-1:0]      o_rbusy,
    input  logic                i_issue,
    input  logic [AW-1:0]       i_issue_addr,
    input  logic                i_flush,
    output logic [NREG-1:0]     o_busy_vec
);

    generate
        if (NRP < 1 || NWP < 1 || AW < 1 || NREG > (1 << AW)) begin : g_param_check
            $error("reg_file_sb: illegal parameters (need NRP>=1, NWP>=1, NREG<=2**AW)");
        end
    endgenerate

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;

    logic [NREG-1:0] w_wr_en;
    logic [XLEN-1:0] w_wr_data [NREG];
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_busy_nxt;

    // Per-register write decode. Ports are scanned in ascending order so the
    // highest-index enabled port targeting a register overwrites lower ones.
    // Index 0 is never decoded, which keeps x0 and busy[0] at their reset 0.
    always_comb begin
        w_wr_en = '0;
        w_set   = '0;
        for (int r = 0; r < NREG; r++) begin
            w_wr_data[r] = '0;
        end
        for (int k = 0; k < NWP; k++) begin
            for (int r = 1; r < NREG; r++) begin
                if (i_wen[k] && (i_waddr[k*AW +: AW] == AW'(r))) begin
                    w_wr_en[r]   = 1'b1;
                    w_wr_data[r] = i_wdata[k*XLEN +: XLEN];
                end
            end
        end
        for (int r = 1; r < NREG; r++) begin
            if (i_issue && (i_issue_addr == AW'(r))) begin
                w_set[r] = 1'b1;
            end
        end
    end

    // Flush beats everything; a new producer beats a completing one.
    assign w_busy_nxt = i_flush ? '0 : (w_set | (r_busy & ~w_wr_en));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                r_regs[r] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (w_wr_en[r]) begin
                    r_regs[r] <= w_wr_data[r];
                end
            end
            r_busy <= w_busy_nxt;
        end
    end

    assign o_busy_vec = r_busy;

    // Read ports. A bypass hit returns the writeback data and hides the
    // hazard, since that producer completes this very cycle. Outputs are
    // forced to zero while reset is asserted, even if a write is presented.
    always_comb begin
        o_rdata = '0;
        o_rbusy = '0;
        for (int j = 0; j < NRP; j++) begin
            if (rst_n && i_ren[j] && (i_raddr[j*AW +: AW] != '0)) begin
                o_rdata[j*XLEN +: XLEN] = r_regs[i_raddr[j*AW +: AW]];
                o_rbusy[j]              = r_busy[i_raddr[j*AW +: AW]];
                for (int k = 0; k < NWP; k++) begin
                    if (i_wen[k] && (i_waddr[k*AW +: AW] == i_raddr[j*AW +: AW])) begin
                        o_rdata[j*XLEN +: XLEN] = i_wdata[k*XLEN +: XLEN];
                        o_rbusy[j]              = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: default parameters ----------------
    logic [1:0]   a_wen = '0;
    logic [9:0]   a_waddr = '0;
    logic [127:0] a_wdata = '0;
    logic [1:0]   a_ren = '0;
    logic [9:0]   a_raddr = '0;
    logic [127:0] a_rdata;
    logic [1:0]   a_rbusy;
    logic         a_issue = 1'b0;
    logic [4:0]   a_issue_addr = '0;
    logic         a_flush = 1'b0;
    logic [31:0]  a_busy;

    reg_file_sb dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wen        (a_wen),
        .i_waddr      (a_waddr),
        .i_wdata      (a_wdata),
        .i_ren        (a_ren),
        .i_raddr      (a_raddr),
        .o_rdata      (a_rdata),
        .o_rbusy      (a_rbusy),
        .i_issue      (a_issue),
        .i_issue_addr (a_issue_addr),
        .i_flush      (a_flush),
        .o_busy_vec   (a_busy)
    );

    // ---------------- instance B: parameter sweep ----------------
    logic [0:0]  b_wen = '0;
    logic [3:0]  b_waddr = '0;
    logic [31:0] b_wdata = '0;
    logic [2:0]  b_ren = '0;
    logic [11:0] b_raddr = '0;
    logic [95:0] b_rdata;
    logic [2:0]  b_rbusy;
    logic        b_issue = 1'b0;
    logic [3:0]  b_issue_addr = '0;
    logic        b_flush = 1'b0;
    logic [15:0] b_busy;

    reg_file_sb #(
        .XLEN (32),
        .NREG (16),
        .AW   (4),
        .NRP  (3),
        .NWP  (1)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wen        (b_wen),
        .i_waddr      (b_waddr),
        .i_wdata      (b_wdata),
        .i_ren        (b_ren),
        .i_raddr      (b_raddr),
        .o_rdata      (b_rdata),
        .o_rbusy      (b_rbusy),
        .i_issue      (b_issue),
        .i_issue_addr (b_issue_addr),
        .i_flush      (b_flush),
        .o_busy_vec   (b_busy)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [32:0] exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wa0, wa1;
        logic [63:0] wd0, wd1;
        logic [1:0]  ren;
        logic [4:0]  ra0, ra1;
        logic        iss;
        logic [4:0]  ia;
        logic        fl;
        logic [63:0] ex_rd0, ex_rd1;
        logic [1:0]  ex_rbusy;
        logic [31:0] ex_busy;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(
        input logic [1:0] wen, input logic [4:0] wa0, input logic [4:0] wa1,
        input logic [63:0] wd0, input logic [63:0] wd1,
        input logic [1:0] ren, input logic [4:0] ra0, input logic [4:0] ra1,
        input logic iss, input logic [4:0] ia, input logic fl,
        input logic [63:0] rd0, input logic [63:0] rd1,
        input logic [1:0] rb, input logic [31:0] bv);
        vec_t v;
        v.wen = wen; v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1;
        v.ren = ren; v.ra0 = ra0; v.ra1 = ra1; v.iss = iss; v.ia = ia; v.fl = fl;
        v.ex_rd0 = rd0; v.ex_rd1 = rd1; v.ex_rbusy = rb; v.ex_busy = bv;
        return v;
    endfunction

    task automatic drive_a(input vec_t v);
        a_wen        = v.wen;
        a_waddr      = {v.wa1, v.wa0};
        a_wdata      = {v.wd1, v.wd0};
        a_ren        = v.ren;
        a_raddr      = {v.ra1, v.ra0};
        a_issue      = v.iss;
        a_issue_addr = v.ia;
        a_flush      = v.fl;
    endtask

    task automatic idle_a();
        a_wen = '0; a_waddr = '0; a_wdata = '0; a_ren = '0; a_raddr = '0;
        a_issue = 1'b0; a_issue_addr = '0; a_flush = 1'b0;
    endtask

    // ---------------- sweep reference model ----------------
    logic [31:0] m_regs [16];
    logic [15:0] m_busy;

    task automatic run_sweep(input int cycles);
        logic [3:0]  ra;
        logic [32:0] e;
        logic [15:0] nxt;
        for (int r = 0; r < 16; r++) m_regs[r] = '0;
        m_busy = '0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            b_wen        = 1'($urandom_range(0, 1));
            b_waddr      = 4'($urandom_range(0, 15));
            b_wdata      = $urandom;
            b_issue      = ($urandom_range(0, 2) == 0);
            b_issue_addr = 4'($urandom_range(0, 15));
            b_flush      = ($urandom_range(0, 31) == 0);
            for (int j = 0; j < 3; j++) begin
                b_ren[j] = ($urandom_range(0, 3) != 0);
                b_raddr[j*4 +: 4] = ($urandom_range(0, 3) == 0) ? b_waddr : 4'($urandom_range(0, 15));
            end
            #1;
            for (int j = 0; j < 3; j++) begin
                ra = b_raddr[j*4 +: 4];
                if (!b_ren[j] || ra == 4'd0)         e = '0;
                else if (b_wen[0] && b_waddr == ra)  e = {1'b0, b_wdata};
                else                                 e = {m_busy[ra], m_regs[ra]};
                exp_q.push_back(e);
            end
            for (int j = 0; j < 3; j++) begin
                e = exp_q.pop_front();
                chk($sformatf("sweep_c%0d_p%0d_rd", c, j), 64'(b_rdata[j*32 +: 32]), 64'(e[31:0]));
                chk($sformatf("sweep_c%0d_p%0d_rbusy", c, j), 64'(b_rbusy[j]), 64'(e[32]));
            end
            @(posedge clk);
            if (b_wen[0] && b_waddr != 4'd0) m_regs[b_waddr] = b_wdata;
            nxt = m_busy;
            if (b_wen[0] && b_waddr != 4'd0) nxt[b_waddr] = 1'b0;
            if (b_issue && b_issue_addr != 4'd0) nxt[b_issue_addr] = 1'b1;
            if (b_flush) nxt = '0;
            m_busy = nxt;
            #1;
            chk($sformatf("sweep_c%0d_busy", c), 64'(b_busy), 64'(m_busy));
        end
        @(negedge clk);
        b_wen = '0; b_ren = '0; b_issue = 1'b0; b_flush = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        //           wen   wa0 wa1 wd0        wd1        ren   ra0 ra1 iss ia  fl  rd0        rd1        rb    busy
        vecs[0]  = mk(2'b01, 7, 0, 64'h1234, 64'h0,    2'b11, 7, 0, 0, 0, 0, 64'h1234, 64'h0,    2'b00, 32'h0);
        vecs[1]  = mk(2'b00, 0, 0, 64'h0,    64'h0,    2'b01, 7, 7, 0, 0, 0, 64'h1234, 64'h0,    2'b00, 32'h0);
        vecs[2]  = mk(2'b01, 0, 0, 64'hFF,   64'h0,    2'b11, 0, 0, 0, 0, 0, 64'h0,    64'h0,    2'b00, 32'h0);
        vecs[3]  = mk(2'b00, 0, 0, 64'h0,    64'h0,    2'b11, 0, 7, 0, 0, 0, 64'h0,    64'h1234, 2'b00, 32'h0);
        vecs[4]  = mk(2'b11, 9, 9, 64'hAAAA, 64'hBBBB, 2'b11, 9, 9, 0, 0, 0, 64'hBBBB, 64'hBBBB, 2'b00, 32'h0);
        vecs[5]  = mk(2'b00, 0, 0, 64'h0,    64'h0,    2'b11, 9, 9, 0, 0, 0, 64'hBBBB, 64'hBBBB, 2'b00, 32'h0);
        vecs[6]  = mk(2'b00, 0, 0, 64'h0,    64'h0,    2'b01, 5, 0, 1, 5, 0, 64'h0,    64'h0,    2'b00, 32'h20);
        vecs[7]  = mk(2'b00, 0, 0, 64'h0,    64'h0,    2'b11, 5, 9, 0, 0, 0, 64'h0,    64'hBBBB, 2'b01, 32'h20);
        vecs[8]  = mk(2'b10, 0, 5, 64'h0,    64'h77,   2'b11, 5, 5, 0, 0, 0, 64'h77,   64'h77,   2'b00, 32'h0);
        vecs[9]  = mk(2'b00, 0, 0, 64'h0,    64'h0,    2'b11, 5, 5, 0, 0, 0, 64'h77,   64'h77,   2'b00, 32'h0);
        vecs[10] = mk(2'b00, 0, 0, 64'h0,    64'h0,    2'b00, 0, 0, 1, 6, 0, 64'h0,    64'h0,    2'b00, 32'h40);
        vecs[11] = mk(2'b01, 6, 0, 64'h66,   64'h0,    2'b01, 6, 0, 1, 6, 0, 64'h66,   64'h0,    2'b00, 32'h40);
        vecs[12] = mk(2'b00, 0, 0, 64'h0,    64'h0,    2'b11, 6, 6, 1, 10, 0, 64'h66,  64'h66,   2'b11, 32'h440);
        vecs[13] = mk(2'b00, 0, 0, 64'h0,    64'h0,    2'b11, 10, 6, 1, 8, 1, 64'h0,   64'h66,   2'b11, 32'h0);
        vecs[14] = mk(2'b00, 0, 0, 64'h0,    64'h0,    2'b11, 6, 10, 1, 0, 0, 64'h66,  64'h0,    2'b00, 32'h0);
        vecs[15] = mk(2'b01, 3, 0, 64'h5A,   64'h0,    2'b01, 3, 0, 0, 0, 0, 64'h5A,   64'h0,    2'b00, 32'h0);

        // Reset state: outputs zero with a live read request.
        a_ren = 2'b11;
        a_raddr = {5'd2, 5'd1};
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(a_busy), 64'h0);
        chk("reset_rd0", a_rdata[63:0], 64'h0);
        chk("reset_rbusy", 64'(a_rbusy), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_a();

        // Table-driven vectors.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive_a(vecs[i]);
            #1;
            chk($sformatf("v%0d_rd0", i), a_rdata[63:0], vecs[i].ex_rd0);
            chk($sformatf("v%0d_rd1", i), a_rdata[127:64], vecs[i].ex_rd1);
            chk($sformatf("v%0d_rbusy", i), 64'(a_rbusy), 64'(vecs[i].ex_rbusy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_busy", i), 64'(a_busy), 64'(vecs[i].ex_busy));
        end

        // Mid-run reset after x3 holds 0x5A and x4 is busy.
        @(negedge clk);
        idle_a();
        a_issue = 1'b1; a_issue_addr = 5'd4;
        a_ren = 2'b01; a_raddr = {5'd0, 5'd3};
        #1;
        chk("pre_reset_rd_x3", a_rdata[63:0], 64'h5A);
        @(posedge clk);
        #1;
        chk("pre_reset_busy", 64'(a_busy), 64'h10);
        #1;
        a_issue = 1'b0;
        a_ren = 2'b11; a_raddr = {5'd4, 5'd3};
        a_wen = 2'b01; a_waddr = {5'd0, 5'd3}; a_wdata = {64'h0, 64'h99};
        rst_n = 1'b0;
        #1;
        chk("in_reset_busy", 64'(a_busy), 64'h0);
        chk("in_reset_rd0", a_rdata[63:0], 64'h0);
        chk("in_reset_rbusy", 64'(a_rbusy), 64'h0);
        @(negedge clk);
        a_wen = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_rd_x3", a_rdata[63:0], 64'h0);
        chk("post_reset_busy", 64'(a_busy), 64'h0);
        @(negedge clk);
        idle_a();

        // Randomised sweep on the small configuration.
        run_sweep(10000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
